// File: rtl/fios_res_collect.sv
// Collects s 17-bit Montgomery result words (LSW first) and performs the final
// conditional subtraction of p on the fly, presenting R mod p for R < 2p.
module fios_res_collect #(
  parameter int s = 8
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              res_valid_i,
  input  logic [16:0]       res_i,
  input  logic [s*17-1:0]   p_i,
  output logic [s*17-1:0]   result_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              busy_o,
  output logic              overflow_o
);

  localparam int CW = (s > 1) ? $clog2(s) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     word_idx;
  logic              borrow;
  logic              b_in;
  logic              b_out;
  logic              accept;
  logic              transfer;
  logic              last_word;
  logic [16:0]       p_k;
  logic [16:0]       diff_k;
  logic [s*17-1:0]   raw_q;
  logic [s*17-1:0]   diff_q;
  logic [s*17-1:0]   raw_next;
  logic [s*17-1:0]   diff_next;

  // A word arriving in the transfer cycle of HOLD starts the next result.
  always_comb begin
    transfer  = (state == HOLD) && valid_o && ready_i;
    accept    = res_valid_i && ((state == IDLE) || (state == COLLECT) || transfer);
    word_idx  = (state == COLLECT) ? cnt : '0;
    b_in      = (state == COLLECT) && borrow;
    last_word = (word_idx == CW'(s - 1));
    p_k       = '0;
    raw_next  = raw_q;
    diff_next = diff_q;
    for (int k = 0; k < s; k++) begin
      if (accept && (CW'(k) == word_idx))
        p_k = p_i[k*17 +: 17];
    end
    {b_out, diff_k} = {1'b0, res_i} - {1'b0, p_k} - {17'b0, b_in};
    for (int k = 0; k < s; k++) begin
      if (CW'(k) == word_idx) begin
        raw_next[k*17 +: 17]  = res_i;
        diff_next[k*17 +: 17] = diff_k;
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state      <= IDLE;
      cnt        <= '0;
      borrow     <= 1'b0;
      raw_q      <= '0;
      diff_q     <= '0;
      result_o   <= '0;
      valid_o    <= 1'b0;
      busy_o     <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      if (accept) begin
        raw_q  <= raw_next;
        diff_q <= diff_next;
        borrow <= b_out;
        busy_o <= 1'b1;
        if (last_word) begin
          // Final borrow set means R < p, so the unsubtracted words are the answer.
          cnt      <= '0;
          state    <= HOLD;
          valid_o  <= 1'b1;
          result_o <= b_out ? raw_next : diff_next;
        end else begin
          cnt     <= word_idx + 1'b1;
          state   <= COLLECT;
          valid_o <= 1'b0;
        end
      end else if (transfer) begin
        state   <= IDLE;
        busy_o  <= 1'b0;
        valid_o <= 1'b0;
      end else if ((state == HOLD) && res_valid_i) begin
        overflow_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fios_res_collect.sv
// Bench for fios_res_collect with s=2: directed vectors plus randomized results
// checked against a whole-number model (R >= P ? R - P : R).
module tb_fios_res_collect;

  localparam int S = 2;
  localparam int W = S * 17;

  logic          clock_i = 1'b0;
  logic          reset_i;
  logic          res_valid_i;
  logic [16:0]   res_i;
  logic [W-1:0]  p_i;
  logic [W-1:0]  result_o;
  logic          valid_o;
  logic          ready_i;
  logic          busy_o;
  logic          overflow_o;

  int tests = 0;
  int fails = 0;

  fios_res_collect #(.s(S)) dut (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .res_valid_i (res_valid_i),
    .res_i       (res_i),
    .p_i         (p_i),
    .result_o    (result_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .busy_o      (busy_o),
    .overflow_o  (overflow_o)
  );

  always #5 clock_i = ~clock_i;

  function automatic logic [W-1:0] model(input logic [16:0] w0, input logic [16:0] w1,
                                         input logic [W-1:0] p);
    logic [W-1:0] r;
    r = {w1, w0};
    return (r >= p) ? (r - p) : r;
  endfunction

  // Drives two words on consecutive cycles; returns at the negedge after word 1 is taken.
  task automatic send_pair(input logic [16:0] w0, input logic [16:0] w1);
    @(negedge clock_i); res_valid_i = 1'b1; res_i = w0;
    @(negedge clock_i); res_i = w1;
    @(negedge clock_i); res_valid_i = 1'b0;
  endtask

  task automatic test_reset;
    reset_i = 1'b1; res_valid_i = 1'b0; res_i = '0; ready_i = 1'b1;
    p_i = {17'h00000, 17'h00005};
    repeat (2) @(negedge clock_i);
    tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", valid_o); end
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy_o); end
    tests++; if (overflow_o !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b want 0", overflow_o); end
    tests++; if (result_o !== '0) begin fails++; $display("FAIL reset_result got %h want 0", result_o); end
    reset_i = 1'b0;
    @(negedge clock_i);
  endtask

  task automatic test_directed;
    logic [16:0] w0s [4] = '{17'd7, 17'd3, 17'd5, 17'h00002};
    logic [16:0] w1s [4] = '{17'd0, 17'd0, 17'd0, 17'h00001};
    logic [W-1:0] ps [4];
    logic [W-1:0] exp_r [4];
    ps[0] = 34'd5; ps[1] = 34'd5; ps[2] = 34'd5; ps[3] = {17'h00000, 17'h1FFFF};
    exp_r[0] = 34'd2; exp_r[1] = 34'd3; exp_r[2] = 34'd0; exp_r[3] = 34'd3;
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      p_i = ps[i];
      @(negedge clock_i); res_valid_i = 1'b1; res_i = w0s[i];
      @(negedge clock_i);
      tests++; if (valid_o !== 1'b0 || busy_o !== 1'b1) begin fails++;
        $display("FAIL dir%0d_mid valid=%b busy=%b want 0/1", i, valid_o, busy_o); end
      res_i = w1s[i];
      @(negedge clock_i); res_valid_i = 1'b0;
      tests++; if (valid_o !== 1'b1 || result_o !== exp_r[i]) begin fails++;
        $display("FAIL dir%0d_result valid=%b got %h want %h", i, valid_o, result_o, exp_r[i]); end
      @(negedge clock_i);
      tests++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin fails++;
        $display("FAIL dir%0d_idle valid=%b busy=%b want 0/0", i, valid_o, busy_o); end
    end
  endtask

  task automatic test_hold_overflow;
    p_i = 34'd5; ready_i = 1'b0;
    send_pair(17'd7, 17'd0);
    tests++; if (valid_o !== 1'b1 || result_o !== 34'd2) begin fails++;
      $display("FAIL hold_first valid=%b got %h want 2", valid_o, result_o); end
    res_valid_i = 1'b1; res_i = 17'd9;
    @(negedge clock_i); res_valid_i = 1'b0;
    tests++; if (overflow_o !== 1'b1) begin fails++; $display("FAIL hold_ovf got %b want 1", overflow_o); end
    for (int c = 0; c < 4; c++) begin
      tests++; if (valid_o !== 1'b1 || result_o !== 34'd2) begin fails++;
        $display("FAIL hold_stable%0d valid=%b got %h want 2", c, valid_o, result_o); end
      @(negedge clock_i);
    end
    ready_i = 1'b1;
    @(negedge clock_i);
    tests++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin fails++;
      $display("FAIL hold_release valid=%b busy=%b want 0/0", valid_o, busy_o); end
    send_pair(17'd3, 17'd0);
    tests++; if (valid_o !== 1'b1 || result_o !== 34'd3) begin fails++;
      $display("FAIL hold_after_drop got %h want 3", result_o); end
    tests++; if (overflow_o !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %b want 1", overflow_o); end
    @(negedge clock_i);
  endtask

  task automatic test_reset_mid;
    p_i = 34'd5; ready_i = 1'b1;
    @(negedge clock_i); res_valid_i = 1'b1; res_i = 17'd7;
    @(negedge clock_i); res_valid_i = 1'b0; reset_i = 1'b1;
    #1;
    tests++; if (busy_o !== 1'b0 || overflow_o !== 1'b0 || result_o !== '0 || valid_o !== 1'b0) begin fails++;
      $display("FAIL rst_async busy=%b ovf=%b valid=%b res=%h want all 0", busy_o, overflow_o, valid_o, result_o); end
    #2 reset_i = 1'b0;
    repeat (2) @(negedge clock_i);
    tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL rst_novalid got %b want 0", valid_o); end
    send_pair(17'd7, 17'd0);
    tests++; if (valid_o !== 1'b1 || result_o !== 34'd2) begin fails++;
      $display("FAIL rst_restart valid=%b got %h want 2", valid_o, result_o); end
    @(negedge clock_i);
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] e1, e2;
    logic [16:0] a0, a1, b0, b1;
    p_i = 34'd5; ready_i = 1'b1;
    a0 = 17'd7; a1 = 17'd0; b0 = 17'd4; b1 = 17'd0;
    e1 = model(a0, a1, p_i); e2 = model(b0, b1, p_i);
    @(negedge clock_i); res_valid_i = 1'b1; res_i = a0;
    @(negedge clock_i); res_i = a1;
    @(negedge clock_i); res_i = b0;
    tests++; if (valid_o !== 1'b1 || result_o !== e1) begin fails++;
      $display("FAIL b2b_first valid=%b got %h want %h", valid_o, result_o, e1); end
    @(negedge clock_i); res_i = b1;
    tests++; if (valid_o !== 1'b0 || busy_o !== 1'b1) begin fails++;
      $display("FAIL b2b_gap valid=%b busy=%b want 0/1", valid_o, busy_o); end
    @(negedge clock_i); res_valid_i = 1'b0;
    tests++; if (valid_o !== 1'b1 || result_o !== e2) begin fails++;
      $display("FAIL b2b_second valid=%b got %h want %h", valid_o, result_o, e2); end
    @(negedge clock_i);
  endtask

  task automatic test_random;
    logic [16:0] w [2];
    logic [W-1:0] p, r, e;
    int g, d;
    for (int it = 0; it < 24; it++) begin
      // Keep R < 2p as the multiplier guarantees; p nonzero.
      p = {17'($urandom_range(0, 3)), 17'($urandom)};
      if (p == 0) p = 34'd1;
      r = (p * 2 > 34'h3FFFFFFFF) ? {$urandom, $urandom} % (p * 2)
                                   : ({$urandom, $urandom} % (p * 2));
      w[0] = r[16:0]; w[1] = r[33:17];
      e = model(w[0], w[1], p);
      p_i = p; ready_i = 1'b0;
      for (int k = 0; k < S; k++) begin
        g = $urandom_range(0, 2);
        repeat (g) begin @(negedge clock_i); res_valid_i = 1'b0; res_i = 17'($urandom); end
        @(negedge clock_i); res_valid_i = 1'b1; res_i = w[k];
      end
      @(negedge clock_i); res_valid_i = 1'b0;
      tests++; if (valid_o !== 1'b1 || result_o !== e) begin fails++;
        $display("FAIL rand%0d R=%h p=%h valid=%b got %h want %h", it, r, p, valid_o, result_o, e); end
      d = $urandom_range(0, 3);
      repeat (d) @(negedge clock_i);
      tests++; if (valid_o !== 1'b1 || result_o !== e) begin fails++;
        $display("FAIL rand%0d_hold got %h want %h", it, result_o, e); end
      ready_i = 1'b1;
      @(negedge clock_i);
      tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL rand%0d_done valid=%b want 0", it, valid_o); end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_hold_overflow;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fios_res_collect.md
FIOS_RES_COLLECT -- requirements
Module: fios_res_collect

Interface
REQ-001 SHALL have parameter s, default 8, giving the number of 17-bit words per Montgomery result (s >= 1).
REQ-002 SHALL have port clock_i  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_i  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port res_valid_i  input  1  qualifies res_i; one result word per asserted cycle.
REQ-005 SHALL have port res_i  input  17  result word from the multiplier RES_o output, least significant word first.
REQ-006 SHALL have port p_i  input  s*17  modulus, word k at bits [17k+16:17k]; held stable by the system while busy_o=1.
REQ-007 SHALL have port result_o  output  s*17  reduced result, (R mod p) for R < 2p.
REQ-008 SHALL have port valid_o  output  1  result_o valid.
REQ-009 SHALL have port ready_i  input  1  consumer accepts result_o when valid_o=1 and ready_i=1.
REQ-010 SHALL have port busy_o  output  1  high in COLLECT or HOLD.
REQ-011 SHALL have port overflow_o  output  1  sticky flag: a word arrived and was dropped.

Function
REQ-012 SHALL implement the states IDLE, COLLECT and HOLD.
REQ-013 SHALL store each accepted word in a raw buffer slot indexed by a word counter of width max(1,clog2(s)).
REQ-014 In the same cycle, SHALL compute diff_k = res_i - p_k - borrow.
  - diff_k is stored in a diff buffer.
  - The registered borrow is updated.
  - Borrow is 0 on the first word of every result.
REQ-015 IDLE, res_valid_i=1: SHALL accept word 0 and go to COLLECT, or to HOLD when s=1.
REQ-016 COLLECT, res_valid_i=1: SHALL accept word k.
  - When k=s-1, go to HOLD.
  - Otherwise stay in COLLECT.
  - Gap cycles (res_valid_i=0) SHALL hold all state.
REQ-017 On entry to HOLD, SHALL select result_o from the final borrow.
  - Final borrow = 0 (R >= p): result_o = diff buffer.
  - Final borrow = 1: result_o = raw buffer.
  - Selection is registered, so valid_o=1 in the cycle after the last word is accepted (latency 1).
REQ-018 While valid_o=1 and ready_i=0, SHALL hold result_o and valid_o unchanged.
REQ-019 HOLD, valid_o=1 and ready_i=1 (transfer): SHALL go to IDLE and deassert valid_o the next cycle.
REQ-020 HOLD, transfer and res_valid_i=1 in the same cycle: SHALL accept that word as word 0 of the next result and go to COLLECT (or HOLD when s=1).
  - The outgoing result_o is not corrupted.
REQ-021 HOLD without transfer, res_valid_i=1: SHALL drop the word and set overflow_o=1 until reset.
REQ-022 SHALL apply all arithmetic modulo 2^17 per word, with a 1-bit borrow.
REQ-023 SHALL NOT normalize values with R >= 2p.
REQ-024 SHALL NOT read p_i outside COLLECT and word-0 acceptance.

Reset
REQ-025 reset_i=1 SHALL immediately clear all of the following, at any point including mid-collection:
  - state to IDLE;
  - counter, borrow, valid_o, busy_o, overflow_o to 0;
  - result_o to 0.
REQ-026 After reset_i deasserts, the first res_valid_i word SHALL be treated as word 0.

Verification (s=2; p_i = {17'h00000, 17'h00005}, i.e. p=5)
REQ-027 Words 7,0 on consecutive cycles with ready_i=1 -> valid_o=1 one cycle after the second word; result_o={0,2}; then IDLE.
REQ-028 Words 3,0 -> result_o={0,3} (borrow path); words 5,0 -> result_o={0,0} (equality boundary).
REQ-029 Words 0x00002,0x00001 (R=0x20002) with p=0x1FFFF -> result_o={0,3}, exercising borrow propagation across words.
REQ-030 ready_i=0 for 5 cycles, third word injected during HOLD -> result_o stable; overflow_o=1; word dropped; result delivered once ready_i=1.
REQ-031 reset_i pulsed after word 0 -> valid_o stays 0; the next words 7,0 yield {0,2}; back-to-back transfer and new word 0 in the same cycle -> both results correct.
